palette_writer: RTL and testbench

//  Write-side companion to the palette mixer: accepts 8-bit-per-channel colour commands, packs each into
//  the 16-bit big-endian palette word (RGB565 or ARGB4444) and issues byte writes into the palette RAM

---
 rtl/gpu_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/palette_writer.sv | 164 ++++++++++++++++
 tb/tb_palette_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions for the palette write path: command layout, FSM states,
// colour packing and palette byte addressing.
package gpu_pkg;

    localparam logic [19:0] PALETTE_ADDR_DEF = 20'h04000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2
    } pw_state_t;

    typedef struct packed {
        logic        mode565;
        logic [7:0]  index;
        logic [7:0]  count;
        logic [15:0] word;
    } pal_cmd_t;

    // 4444 stores transparency (inverted alpha) in the top nibble.
    function automatic logic [15:0] pack_pal_word(input logic       mode565,
                                                  input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b,
                                                  input logic [7:0] a);
        logic [15:0] w;
        if (mode565) begin
            w = {r[7:3], g[7:2], b[7:3]};
        end else begin
            w = {~a[7:4], r[7:4], g[7:4], b[7:4]};
        end
        return w;
    endfunction

    function automatic logic [19:0] pal_byte_addr(input logic [19:0] base,
                                                  input logic        mode565,
                                                  input logic [7:0]  idx,
                                                  input logic        lo_byte);
        return base + {10'd0, mode565, idx, lo_byte};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered empty/ready flags; ready stays low while in reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             empty_nxt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             ready_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && ready_r;
    assign pop_ok_s  = pop && !empty_r;
    assign ready     = ready_r;
    assign empty     = empty_r;
    assign empty_nxt = (count_nxt_s == (AW + 1)'(0));
    assign pop_data  = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + (AW + 1)'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - (AW + 1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s != FULL_CNT);
            empty_r <= (count_nxt_s == (AW + 1)'(0));
        end
    end

endmodule

// File: rtl/palette_writer.sv
// Packs colour commands into big-endian palette words and streams them as byte
// writes through the shared host port, with multi-entry fills and index wrap.
module palette_writer
    import gpu_pkg::*;
#(
    parameter logic [19:0] PALETTE_ADDR = PALETTE_ADDR_DEF,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode565,
    input  logic [7:0]  cmd_index,
    input  logic [7:0]  cmd_count,
    input  logic [7:0]  cmd_r,
    input  logic [7:0]  cmd_g,
    input  logic [7:0]  cmd_b,
    input  logic [7:0]  cmd_a,
    output logic        wr_ena,
    output logic [19:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_grant,
    output logic        busy,
    output logic        done
);

    pal_cmd_t    cmd_s;
    pal_cmd_t    head_s;
    logic        fifo_empty_s;
    logic        fifo_empty_nxt_s;
    logic        fifo_pop_s;

    pw_state_t   state_r,    state_nxt_s;
    logic        mode_r,     mode_nxt_s;
    logic [7:0]  idx_r,      idx_nxt_s;
    logic [7:0]  rem_r,      rem_nxt_s;
    logic [15:0] word_r,     word_nxt_s;
    logic        wr_ena_r,   wr_ena_nxt_s;
    logic [19:0] wr_addr_r,  wr_addr_nxt_s;
    logic [7:0]  wr_data_r,  wr_data_nxt_s;
    logic        done_r,     done_nxt_s;
    logic        busy_r;

    // Command packing at enqueue time.
    always_comb begin
        cmd_s         = '0;
        cmd_s.mode565 = cmd_mode565;
        cmd_s.index   = cmd_index;
        cmd_s.count   = cmd_count;
        cmd_s.word    = pack_pal_word(cmd_mode565, cmd_r, cmd_g, cmd_b, cmd_a);
    end

    sync_fifo #(
        .WIDTH ($bits(pal_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (cmd_s),
        .ready     (cmd_ready),
        .pop       (fifo_pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .empty_nxt (fifo_empty_nxt_s)
    );

    // Write sequencer: next state, working registers and next host-port outputs.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        idx_nxt_s     = idx_r;
        rem_nxt_s     = rem_r;
        word_nxt_s    = word_r;
        wr_ena_nxt_s  = wr_ena_r;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        done_nxt_s    = 1'b0;
        fifo_pop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s    = 1'b1;
                    mode_nxt_s    = head_s.mode565;
                    idx_nxt_s     = head_s.index;
                    rem_nxt_s     = head_s.count;
                    word_nxt_s    = head_s.word;
                    wr_ena_nxt_s  = 1'b1;
                    wr_addr_nxt_s = pal_byte_addr(PALETTE_ADDR, head_s.mode565, head_s.index, 1'b0);
                    wr_data_nxt_s = head_s.word[15:8];
                    state_nxt_s   = WR_HI;
                end else begin
                    wr_ena_nxt_s  = 1'b0;
                end
            end
            WR_HI: begin
                if (wr_grant) begin
                    wr_addr_nxt_s = pal_byte_addr(PALETTE_ADDR, mode_r, idx_r, 1'b1);
                    wr_data_nxt_s = word_r[7:0];
                    state_nxt_s   = WR_LO;
                end else begin
                    state_nxt_s   = WR_HI;
                end
            end
            WR_LO: begin
                if (wr_grant) begin
                    if (rem_r != 8'd0) begin
                        // Index wraps within the bank; the mode bit is never touched.
                        idx_nxt_s     = idx_r + 8'd1;
                        rem_nxt_s     = rem_r - 8'd1;
                        wr_addr_nxt_s = pal_byte_addr(PALETTE_ADDR, mode_r, idx_r + 8'd1, 1'b0);
                        wr_data_nxt_s = word_r[15:8];
                        state_nxt_s   = WR_HI;
                    end else begin
                        wr_ena_nxt_s  = 1'b0;
                        done_nxt_s    = 1'b1;
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    state_nxt_s = WR_LO;
                end
            end
            default: begin
                wr_ena_nxt_s = 1'b0;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            mode_r    <= 1'b0;
            idx_r     <= 8'd0;
            rem_r     <= 8'd0;
            word_r    <= 16'd0;
            wr_ena_r  <= 1'b0;
            wr_addr_r <= 20'd0;
            wr_data_r <= 8'd0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mode_r    <= mode_nxt_s;
            idx_r     <= idx_nxt_s;
            rem_r     <= rem_nxt_s;
            word_r    <= word_nxt_s;
            wr_ena_r  <= wr_ena_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= !fifo_empty_nxt_s || (state_nxt_s != IDLE);
        end
    end

    assign wr_ena  = wr_ena_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign done    = done_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_palette_writer.sv
// Directed self-checking bench for palette_writer: packing, addressing, fill wrap,
// grant stalls, FIFO back-pressure and mid-fill reset.
module tb_palette_writer;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode565;
    logic [7:0]  cmd_index;
    logic [7:0]  cmd_count;
    logic [7:0]  cmd_r;
    logic [7:0]  cmd_g;
    logic [7:0]  cmd_b;
    logic [7:0]  cmd_a;
    logic        wr_ena;
    logic [19:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_grant;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_errors;
    int          done_cnt;
    logic [27:0] wq[$];
    logic [27:0] exp_q[$];

    palette_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode565 (cmd_mode565),
        .cmd_index   (cmd_index),
        .cmd_count   (cmd_count),
        .cmd_r       (cmd_r),
        .cmd_g       (cmd_g),
        .cmd_b       (cmd_b),
        .cmd_a       (cmd_a),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_grant    (wr_grant),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Record every granted byte and every done pulse.
    always @(posedge clk) begin
        if (reset_n && wr_ena && wr_grant) begin
            wq.push_back({wr_addr, wr_data});
        end
        if (done) begin
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_cmd(input logic m, input logic [7:0] idx, input logic [7:0] cnt,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] a);
        int t = 0;
        cmd_valid   = 1'b1;
        cmd_mode565 = m;
        cmd_index   = idx;
        cmd_count   = cnt;
        cmd_r       = r;
        cmd_g       = g;
        cmd_b       = b;
        cmd_a       = a;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        if (!cmd_ready) begin
            check("cmd_accept", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((busy || done) && t < 500) begin
            @(negedge clk);
            t = t + 1;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_nwr"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            check($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic start_test();
        wq.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_mode565 = 1'b0;
        cmd_index   = 8'd0;
        cmd_count   = 8'd0;
        cmd_r       = 8'd0;
        cmd_g       = 8'd0;
        cmd_b       = 8'd0;
        cmd_a       = 8'd0;
        wr_grant    = 1'b0;
        n_checks    = 0;
        n_errors    = 0;
        done_cnt    = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_ena",   32'(wr_ena),    32'd0);
        check("rst_addr",  32'(wr_addr),   32'd0);
        check("rst_data",  32'(wr_data),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Test 1: 565 single entry, cycle-accurate latency.
        start_test();
        wr_grant = 1'b1;
        send_cmd(1'b1, 8'h05, 8'd0, 8'hFF, 8'h80, 8'h08, 8'h00);
        check("t1_pop_cycle", 32'(wr_ena), 32'd0);
        @(negedge clk);
        check("t1_hi", {3'd0, wr_ena, wr_addr, wr_data}, {4'h1, 20'h0420A, 8'hFC});
        @(negedge clk);
        check("t1_lo", {3'd0, wr_ena, wr_addr, wr_data}, {4'h1, 20'h0420B, 8'h01});
        @(negedge clk);
        check("t1_done_hi", {30'd0, done, wr_ena}, 32'h2);
        @(negedge clk);
        check("t1_done_lo", {30'd0, done, busy}, 32'h0);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Test 2: 4444 packing, opaque then fully transparent alpha.
        start_test();
        send_cmd(1'b0, 8'h10, 8'd0, 8'h3C, 8'hA5, 8'hF0, 8'hFF);
        wait_idle("t2a_idle");
        send_cmd(1'b0, 8'h10, 8'd0, 8'h3C, 8'hA5, 8'hF0, 8'h00);
        wait_idle("t2b_idle");
        exp_q = '{{20'h04020, 8'h03}, {20'h04021, 8'hAF}, {20'h04020, 8'hF3}, {20'h04021, 8'hAF}};
        cmp_writes("t2");
        check("t2_done_cnt", 32'(done_cnt), 32'd2);

        // Test 3: fill wrapping FF -> 00 inside the 565 bank.
        start_test();
        send_cmd(1'b1, 8'hFE, 8'd3, 8'hFF, 8'h80, 8'h08, 8'h00);
        wait_idle("t3_idle");
        exp_q = '{{20'h043FC, 8'hFC}, {20'h043FD, 8'h01}, {20'h043FE, 8'hFC}, {20'h043FF, 8'h01},
                  {20'h04200, 8'hFC}, {20'h04201, 8'h01}, {20'h04202, 8'hFC}, {20'h04203, 8'h01}};
        cmp_writes("t3");
        check("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Test 4: grant withheld while the high byte is presented.
        start_test();
        wr_grant = 1'b0;
        send_cmd(1'b1, 8'h05, 8'd0, 8'hFF, 8'h80, 8'h08, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold%0d", i), {3'd0, wr_ena, wr_addr, wr_data}, {4'h1, 20'h0420A, 8'hFC});
            @(negedge clk);
        end
        wr_grant = 1'b1;
        @(negedge clk);
        check("t4_lo", {3'd0, wr_ena, wr_addr, wr_data}, {4'h1, 20'h0420B, 8'h01});
        wait_idle("t4_idle");
        exp_q = '{{20'h0420A, 8'hFC}, {20'h0420B, 8'h01}};
        cmp_writes("t4");

        // Test 5: back-pressure; one command sits in the sequencer, four fill the FIFO.
        start_test();
        wr_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b0, 8'h20 + 8'(i), 8'd0, 8'h3C, 8'hA5, 8'hF0, 8'hFF);
        end
        check("t5_full_ready", 32'(cmd_ready), 32'd0);
        check("t5_no_writes", 32'(wq.size()), 32'd0);
        wr_grant = 1'b1;
        send_cmd(1'b0, 8'h25, 8'd0, 8'h3C, 8'hA5, 8'hF0, 8'hFF);
        wait_idle("t5_idle");
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({20'h04040 + 20'(2 * i), 8'h03});
            exp_q.push_back({20'h04041 + 20'(2 * i), 8'hAF});
        end
        cmp_writes("t5");
        check("t5_done_cnt", 32'(done_cnt), 32'd6);

        // Test 6: reset asserted after three bytes of a fill.
        start_test();
        send_cmd(1'b1, 8'hFE, 8'd3, 8'hFF, 8'h80, 8'h08, 8'h00);
        for (int t = 0; t < 100 && wq.size() < 3; t++) begin
            @(negedge clk);
        end
        check("t6_three_bytes", 32'(wq.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_rst_outs", {wr_ena, busy, done, cmd_ready, wr_addr, wr_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_more_wr", 32'(wq.size()), 32'd3);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_done_cnt", 32'(done_cnt), 32'd0);
        start_test();
        send_cmd(1'b1, 8'h05, 8'd0, 8'hFF, 8'h80, 8'h08, 8'h00);
        wait_idle("t6_idle");
        exp_q = '{{20'h0420A, 8'hFC}, {20'h0420B, 8'h01}};
        cmp_writes("t6");
        check("t6_new_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
